foreign_prefix_seq: RTL and testbench

Byte-serial sequencer for the foreign (x86) instruction front end. It consumes instruction bytes one per cycle and tracks prefix and escape level (legacy → 0F → 38/3A). It accumulates the 16-bit prefix mask used by the foreign decoder datapath and hands a completed descriptor (mask, opcode byte, length, error) to the decode stage through a valid/ready handshake.

---
 rtl/foreign_pkg.sv | 48 ++++
 rtl/foreign_prefix_classify.sv | 73 +++++++
 rtl/foreign_prefix_seq.sv | 109 ++++++++++
 tb/tb_foreign_prefix_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/foreign_pkg.sv
// Shared types and byte constants for the foreign (x86) prefix sequencer.
// Holds the state encoding, prefix/escape byte values and desc_mask field layout.
package foreign_pkg;

    typedef enum logic [1:0] {
        S_PFX  = 2'd0,
        S_ESC1 = 2'd1,
        S_ESC2 = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [7:0] P_OPSZ  = 8'h66;
    localparam logic [7:0] P_REPNE = 8'hF2;
    localparam logic [7:0] P_REP   = 8'hF3;
    localparam logic [7:0] ESC0F   = 8'h0F;
    localparam logic [7:0] ESC38   = 8'h38;
    localparam logic [7:0] ESC3A   = 8'h3A;
    localparam logic [7:0] P_ES    = 8'h26;
    localparam logic [7:0] P_CS    = 8'h2E;
    localparam logic [7:0] P_SS    = 8'h36;
    localparam logic [7:0] P_DS    = 8'h3E;
    localparam logic [7:0] P_FS    = 8'h64;
    localparam logic [7:0] P_GS    = 8'h65;
    localparam logic [7:0] P_ASZ   = 8'h67;
    localparam logic [7:0] P_LOCK  = 8'hF0;

    localparam logic [1:0] OPSZ_66  = 2'b01;
    localparam logic [1:0] OPSZ_F2  = 2'b10;
    localparam logic [1:0] OPSZ_F3  = 2'b11;
    localparam logic [1:0] MAP_0F   = 2'b01;
    localparam logic [1:0] MAP_0F38 = 2'b10;
    localparam logic [1:0] MAP_0F3A = 2'b11;

    localparam int unsigned REX_LSB  = 12;
    localparam int unsigned OPSZ_LSB = 10;
    localparam int unsigned MAP_LSB  = 8;

    localparam logic [15:0] REX_FIELD  = 16'hF000;
    localparam logic [15:0] OPSZ_FIELD = 16'h0C00;
    localparam logic [15:0] MAP_FIELD  = 16'h0300;

    localparam int unsigned MAX_LEN_DEFAULT = 15;

    function automatic logic [15:0] place2(input logic [1:0] code, input int unsigned lsb);
        return 16'(code) << lsb;
    endfunction

endpackage

// File: rtl/foreign_prefix_classify.sv
// Combinational byte classifier: decides how one byte updates the prefix mask
// at the current escape level and whether it ends the instruction.
module foreign_prefix_classify
    import foreign_pkg::*;
(
    input  logic [7:0]  byte_in,
    input  logic [1:0]  level,
    input  logic        is64,
    output logic [15:0] upd_mask,
    output logic [15:0] upd_val,
    output logic        is_legacy,
    output logic        is_rex,
    output logic        is_escape,
    output logic        is_terminal
);

    logic [1:0] opsz_code;

    always_comb begin
        opsz_code = OPSZ_F3;
        if (byte_in == P_OPSZ)
            opsz_code = OPSZ_66;
        else if (byte_in == P_REPNE)
            opsz_code = OPSZ_F2;
    end

    always_comb begin
        upd_mask    = '0;
        upd_val     = '0;
        is_legacy   = 1'b0;
        is_rex      = 1'b0;
        is_escape   = 1'b0;
        is_terminal = 1'b0;
        case (level)
            2'd0: begin
                // Any legacy prefix kills a preceding REX, so they all touch REX_FIELD.
                if (byte_in inside {P_OPSZ, P_REPNE, P_REP}) begin
                    is_legacy = 1'b1;
                    upd_mask  = REX_FIELD | OPSZ_FIELD;
                    upd_val   = place2(opsz_code, OPSZ_LSB);
                end else if (byte_in inside {P_ES, P_CS, P_SS, P_DS, P_FS, P_GS, P_ASZ, P_LOCK}) begin
                    is_legacy = 1'b1;
                    upd_mask  = REX_FIELD;
                end else if (is64 && byte_in[7:4] == 4'h4) begin
                    is_rex   = 1'b1;
                    upd_mask = REX_FIELD;
                    upd_val  = 16'(byte_in[3:0]) << REX_LSB;
                end else if (byte_in == ESC0F) begin
                    is_escape = 1'b1;
                    upd_mask  = MAP_FIELD;
                    upd_val   = place2(MAP_0F, MAP_LSB);
                end else begin
                    is_terminal = 1'b1;
                end
            end
            2'd1: begin
                if (byte_in == ESC38) begin
                    is_escape = 1'b1;
                    upd_mask  = MAP_FIELD;
                    upd_val   = place2(MAP_0F38, MAP_LSB);
                end else if (byte_in == ESC3A) begin
                    is_escape = 1'b1;
                    upd_mask  = MAP_FIELD;
                    upd_val   = place2(MAP_0F3A, MAP_LSB);
                end else begin
                    is_terminal = 1'b1;
                end
            end
            default: is_terminal = 1'b1;
        endcase
    end

endmodule

// File: rtl/foreign_prefix_seq.sv
// Byte-serial x86 prefix/escape sequencer: accumulates the prefix mask and
// length, then holds a descriptor for the decode stage via valid/ready.
module foreign_prefix_seq
    import foreign_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is64,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        byte_ready,
    input  logic        flush,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [15:0] desc_mask,
    output logic [7:0]  desc_opcode,
    output logic [3:0]  desc_len,
    output logic        desc_err
);

    localparam logic [3:0] LEN_LIMIT = 4'(MAX_LEN);

    state_t      state;
    logic [15:0] mask_acc;
    logic [3:0]  len_acc;

    logic [1:0]  level;
    logic [15:0] upd_mask;
    logic [15:0] upd_val;
    logic        is_legacy;
    logic        is_rex;
    logic        is_escape;
    logic        is_terminal;

    logic [15:0] new_mask;
    logic [3:0]  new_len;
    logic        overlen;

    assign level      = 2'(state);
    assign byte_ready = rst & ~flush & (state != S_OUT);

    foreign_prefix_classify u_classify (
        .byte_in     (byte_in),
        .level       (level),
        .is64        (is64),
        .upd_mask    (upd_mask),
        .upd_val     (upd_val),
        .is_legacy   (is_legacy),
        .is_rex      (is_rex),
        .is_escape   (is_escape),
        .is_terminal (is_terminal)
    );

    assign new_mask = (mask_acc & ~upd_mask) | (upd_val & upd_mask);
    assign new_len  = len_acc + 4'd1;
    // Field updates of the forced byte still land in the mask.
    assign overlen  = (new_len == LEN_LIMIT) && !is_terminal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_PFX;
            mask_acc    <= '0;
            len_acc     <= '0;
            desc_valid  <= 1'b0;
            desc_mask   <= '0;
            desc_opcode <= '0;
            desc_len    <= '0;
            desc_err    <= 1'b0;
        end else if (flush) begin
            state       <= S_PFX;
            mask_acc    <= '0;
            len_acc     <= '0;
            desc_valid  <= 1'b0;
            desc_mask   <= '0;
            desc_opcode <= '0;
            desc_len    <= '0;
            desc_err    <= 1'b0;
        end else if (state == S_OUT) begin
            if (desc_ready) begin
                state       <= S_PFX;
                mask_acc    <= '0;
                len_acc     <= '0;
                desc_valid  <= 1'b0;
                desc_mask   <= '0;
                desc_opcode <= '0;
                desc_len    <= '0;
                desc_err    <= 1'b0;
            end
        end else if (byte_valid) begin
            mask_acc <= new_mask;
            len_acc  <= new_len;
            if (is_terminal || overlen) begin
                state       <= S_OUT;
                desc_valid  <= 1'b1;
                desc_mask   <= new_mask;
                desc_opcode <= byte_in;
                desc_len    <= new_len;
                desc_err    <= overlen;
            end else if (is_escape) begin
                state <= (state == S_PFX) ? S_ESC1 : S_ESC2;
            end else if (is_legacy || is_rex) begin
                state <= state;
            end
        end
    end

endmodule

// File: tb/tb_foreign_prefix_seq.sv
// Scoreboard bench for foreign_prefix_seq: directed byte sequences push
// expected descriptors; a monitor pops and compares on each handshake.
module tb_foreign_prefix_seq;

    typedef struct packed {
        logic [15:0] mask;
        logic [7:0]  opcode;
        logic [3:0]  len;
        logic        err;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        is64;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        flush;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_mask;
    logic [7:0]  desc_opcode;
    logic [3:0]  desc_len;
    logic        desc_err;

    int    errors = 0;
    int    checks = 0;
    desc_t exp_q[$];

    foreign_prefix_seq #(.MAX_LEN(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .is64        (is64),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .byte_ready  (byte_ready),
        .flush       (flush),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_mask   (desc_mask),
        .desc_opcode (desc_opcode),
        .desc_len    (desc_len),
        .desc_err    (desc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_desc(input logic [15:0] m, input logic [7:0] op,
                               input logic [3:0] l, input logic e);
        desc_t d;
        d.mask = m; d.opcode = op; d.len = l; d.err = e;
        exp_q.push_back(d);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got byte_ready=0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whenever a descriptor is taken by the consumer.
    always @(negedge clk) begin
        if (rst && !flush && desc_valid && desc_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_desc: got opcode %0h expected none", desc_opcode);
            end else begin
                desc_t d;
                d = exp_q.pop_front();
                check("desc_mask",   32'(desc_mask),   32'(d.mask));
                check("desc_opcode", 32'(desc_opcode), 32'(d.opcode));
                check("desc_len",    32'(desc_len),    32'(d.len));
                check("desc_err",    32'(desc_err),    32'(d.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; is64 = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        flush = 1'b0; desc_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 0);
        check("rst_desc_valid", 32'(desc_valid), 0);
        check("rst_desc_all",   {desc_mask, desc_opcode, desc_len, desc_err, 3'b0}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // REX + opsz + 0F map, with latency check
        expect_desc(16'h8500, 8'hAF, 4'd4, 1'b0);
        send_byte(8'h66); send_byte(8'h48); send_byte(8'h0F);
        check("pre_op_valid", 32'(desc_valid), 0);
        send_byte(8'hAF);
        check("post_op_valid", 32'(desc_valid), 1);
        wait_idle();

        // 66 clears a preceding REX
        expect_desc(16'h0600, 8'hF0, 4'd5, 1'b0);
        send_byte(8'h48); send_byte(8'h66); send_byte(8'h0F); send_byte(8'h38); send_byte(8'hF0);
        wait_idle();

        // 32-bit mode: 48 is an opcode; last rep prefix wins
        is64 = 1'b0;
        expect_desc(16'h0000, 8'h48, 4'd1, 1'b0);
        send_byte(8'h48);
        expect_desc(16'h0B00, 8'h0F, 4'd5, 1'b0);
        send_byte(8'hF3); send_byte(8'hF2); send_byte(8'h0F); send_byte(8'h3A); send_byte(8'h0F);
        wait_idle();
        is64 = 1'b1;

        // Over-length: 15 x 66, 16th byte stalls until handshake
        desc_ready = 1'b0;
        expect_desc(16'h0400, 8'h66, 4'd15, 1'b1);
        for (int i = 0; i < 15; i++) send_byte(8'h66);
        byte_valid = 1'b1;
        byte_in    = 8'h90;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ovl_byte_ready", 32'(byte_ready), 0);
            check("ovl_hold_err",   32'(desc_err), 1);
        end
        expect_desc(16'h0000, 8'h90, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        desc_ready = 1'b1;
        send_byte(8'h90);
        wait_idle();

        // Back-pressure: descriptor held stable for 3 cycles
        desc_ready = 1'b0;
        expect_desc(16'h0000, 8'h90, 4'd1, 1'b0);
        send_byte(8'h90);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid",      32'(desc_valid), 1);
            check("bp_opcode",     32'(desc_opcode), 32'h90);
            check("bp_len",        32'(desc_len), 1);
            check("bp_byte_ready", 32'(byte_ready), 0);
        end
        @(posedge clk);
        #1;
        desc_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 32'(byte_ready), 1);
        check("bp_release_valid", 32'(desc_valid), 0);
        wait_idle();

        // Flush mid-instruction; byte 38 in the flush cycle is dropped
        send_byte(8'hF3); send_byte(8'h0F);
        byte_valid = 1'b1; byte_in = 8'h38; flush = 1'b1;
        @(negedge clk);
        check("flush_byte_ready", 32'(byte_ready), 0);
        @(posedge clk);
        #1;
        flush = 1'b0; byte_valid = 1'b0;
        expect_desc(16'h0000, 8'h90, 4'd1, 1'b0);
        send_byte(8'h90);
        wait_idle();

        // Same with reset instead of flush
        send_byte(8'hF3); send_byte(8'h0F);
        byte_valid = 1'b1; byte_in = 8'h38; rst = 1'b0;
        @(negedge clk);
        check("rst2_byte_ready", 32'(byte_ready), 0);
        @(posedge clk);
        #1;
        check("rst2_desc_valid", 32'(desc_valid), 0);
        check("rst2_desc_all",   {desc_mask, desc_opcode, desc_len, desc_err, 3'b0}, 0);
        rst = 1'b1; byte_valid = 1'b0;
        expect_desc(16'h0000, 8'h90, 4'd1, 1'b0);
        send_byte(8'h90);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
